// File: rtl/mac_accumulator16.sv
// Unsigned 16x16 multiply-accumulate over LEN operand pairs; result strobed 3 edges after the last transfer.
// in_ready is high only while accumulating; define MAC_SATURATE_EN to clamp on carry-out instead of wrapping.

// Combinational 16x16 unsigned array multiplier: rows of gated partial products summed.
module arrayMultiplier16Bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] C
);
  always_comb begin
    C = '0;
    for (int i = 0; i < 16; i++) begin
      if (B[i]) C = C + ({16'd0, A} << i);
    end
  end
endmodule

module mac_accumulator16 #(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        opa_q, opb_q;
  logic               s1_vld_q, s2_vld_q;
  logic [31:0]        prod, preg_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         count_q, count_d;
  logic [ACC_W:0]     sum;
  logic               clr, xfer;

  arrayMultiplier16Bit u_mul (.A(opa_q), .B(opb_q), .C(prod));

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && count_q == 8'(LEN - 1)) state_d = DRAIN;
      end
      // Wait until both pipeline stages have emptied into the accumulator.
      DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum     = {1'b0, acc_q} + (ACC_W + 1)'(preg_q);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (clr) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else begin
      if (xfer) count_d = count_q + 8'd1;
      if (s2_vld_q) begin
        ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC_SATURATE_EN
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      preg_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= xfer;
      s2_vld_q <= s1_vld_q;
      if (xfer) begin
        opa_q <= A;
        opb_q <= B;
      end
      if (s1_vld_q) preg_q <= prod;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign acc_out  = acc_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
